// File: rtl/wb_master_bridge.sv
// Bridges a single-request core load/store port to a classic Wishbone master
// interface. A watchdog turns a missing ack into an error response.
module wb_master_bridge #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_sel,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [AW-1:0]   adr_o,
  output logic [DW-1:0]   dat_o,
  output logic [DW/8-1:0] sel_o,
  input  logic [DW-1:0]   dat_i,
  input  logic            ack_i,
  input  logic            err_i
);

  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [SW-1:0]   sel_q, sel_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          adr_d   = req_addr & ~AW'(3);
          dat_d   = req_wdata;
          sel_d   = req_sel;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          ready_d = 1'b0;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (err_i || ack_i || (cnt_q == 8'(TIMEOUT - 1))) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
          // Error and timeout share one exit; err outranks a simultaneous ack.
          if (err_i || !ack_i) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = we_q ? '0 : dat_i;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign cyc_o     = cyc_q;
  assign stb_o     = stb_q;
  assign we_o      = we_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign sel_o     = sel_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: write, read, alignment, timeout,
// error priority, stray ack and asynchronous reset mid-transfer.
module tb_wb_master_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i, err_i;

  int unsigned checks = 0;
  int unsigned errors = 0;

  wb_master_bridge #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .dat_o(dat_o), .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] sel);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_sel   = sel;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_sel = '0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_cyc_stb_we", {29'd0, cyc_o, stb_o, we_o}, 32'd0);
    chk("rst_adr", adr_o, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_sel", 32'(sel_o), 32'd0);
    step(); step();
    #2 reset = 1'b0;
    step();

    // Write with two wait cycles
    issue(1'b1, 32'h04, 32'hAB, 4'hF);
    step();
    req_valid = 1'b0;
    chk("wr_cyc_stb_we", {29'd0, cyc_o, stb_o, we_o}, 32'd7);
    chk("wr_adr", adr_o, 32'h04);
    chk("wr_dat", dat_o, 32'hAB);
    chk("wr_sel", 32'(sel_o), 32'hF);
    chk("wr_ready_low", 32'(req_ready), 32'd0);
    step();
    chk("wr_wait1_cyc", {30'd0, cyc_o, stb_o}, 32'd3);
    chk("wr_wait1_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("wr_wait2_adr", adr_o, 32'h04);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("wr_done_cyc_stb", {30'd0, cyc_o, stb_o}, 32'd0);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_err", 32'(rsp_err), 32'd0);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_resp_ready", 32'(req_ready), 32'd0);
    step();
    chk("wr_valid_pulse", 32'(rsp_valid), 32'd0);
    chk("wr_ready_back", 32'(req_ready), 32'd1);

    // Zero-wait read
    issue(1'b0, 32'h08, 32'hDEAD, 4'hF);
    step();
    req_valid = 1'b0;
    chk("rd_we", 32'(we_o), 32'd0);
    chk("rd_adr", adr_o, 32'h08);
    dat_i = 32'hAA; ack_i = 1'b1;
    step();
    ack_i = 1'b0; dat_i = 32'h0;
    chk("rd_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rdata", rsp_rdata, 32'hAA);
    chk("rd_err", 32'(rsp_err), 32'd0);
    chk("rd_we_after", 32'(we_o), 32'd0);
    step();
    chk("rd_valid_pulse", 32'(rsp_valid), 32'd0);
    chk("rd_rdata_hold", rsp_rdata, 32'hAA);
    chk("rd_ready_back", 32'(req_ready), 32'd1);

    // Alignment and byte select
    issue(1'b0, 32'h0B, 32'h0, 4'h3);
    step();
    req_valid = 1'b0;
    chk("al_adr", adr_o, 32'h08);
    chk("al_sel", 32'(sel_o), 32'h3);
    dat_i = 32'h55; ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("al_rdata", rsp_rdata, 32'h55);
    step();

    // Timeout: cyc/stb held exactly 16 cycles
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    step();
    req_valid = 1'b0;
    dat_i = 32'h99;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("to_cyc_held", {30'd0, cyc_o, stb_o}, 32'd3);
    end
    step();
    chk("to_cyc_drop", {30'd0, cyc_o, stb_o}, 32'd0);
    chk("to_valid", 32'(rsp_valid), 32'd1);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_rdata", rsp_rdata, 32'h0);
    step();
    chk("to_ready_back", 32'(req_ready), 32'd1);

    // Clean read restores rsp_err=0 before the priority test
    issue(1'b0, 32'h20, 32'h0, 4'hF);
    step();
    req_valid = 1'b0;
    dat_i = 32'h12; ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("pre_err_clear", 32'(rsp_err), 32'd0);
    step();

    // ack and err together: err wins
    issue(1'b0, 32'h24, 32'h0, 4'hF);
    step();
    req_valid = 1'b0;
    dat_i = 32'h77; ack_i = 1'b1; err_i = 1'b1;
    step();
    ack_i = 1'b0; err_i = 1'b0;
    chk("pri_valid", 32'(rsp_valid), 32'd1);
    chk("pri_err", 32'(rsp_err), 32'd1);
    chk("pri_rdata", rsp_rdata, 32'h0);
    step();

    // Stray ack in IDLE is ignored
    ack_i = 1'b1;
    step();
    chk("stray_valid1", 32'(rsp_valid), 32'd0);
    step();
    ack_i = 1'b0;
    chk("stray_valid2", 32'(rsp_valid), 32'd0);
    chk("stray_cyc", 32'(cyc_o), 32'd0);
    chk("stray_ready", 32'(req_ready), 32'd1);
    chk("stray_err_hold", 32'(rsp_err), 32'd1);

    // Async reset while in BUS
    issue(1'b1, 32'h30, 32'h5A, 4'hF);
    step();
    req_valid = 1'b0;
    step();
    chk("ar_in_bus", {30'd0, cyc_o, stb_o}, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("ar_cyc_stb_async", {30'd0, cyc_o, stb_o}, 32'd0);
    chk("ar_valid", 32'(rsp_valid), 32'd0);
    step();
    ack_i = 1'b1;
    #2 reset = 1'b0;
    step();
    ack_i = 1'b0;
    chk("ar_no_rsp", 32'(rsp_valid), 32'd0);
    chk("ar_ready", 32'(req_ready), 32'd1);

    // Normal read after reset, one wait cycle
    issue(1'b0, 32'h04, 32'h0, 4'hF);
    step();
    req_valid = 1'b0;
    chk("post_adr", adr_o, 32'h04);
    step();
    dat_i = 32'h1234; ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("post_valid", 32'(rsp_valid), 32'd1);
    chk("post_rdata", rsp_rdata, 32'h1234);
    chk("post_err", 32'(rsp_err), 32'd0);
    step();
    chk("post_ready", 32'(req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
